// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: branch-kind encodings, default
// PC constants and PC-sequencer state encodings.
package mips_pkg;

  typedef enum logic [2:0] {
    BR_BEQ  = 3'd0,
    BR_BNE  = 3'd1,
    BR_BLEZ = 3'd2,
    BR_BGTZ = 3'd3,
    BR_BLTZ = 3'd4,
    BR_BGEZ = 3'd5
  } br_kind_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
  localparam logic [31:0] EXC_PC_DEFAULT   = 32'h0000_4180;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } pcs_state_e;

endpackage

// File: rtl/branch_cond.sv
// D-stage branch condition evaluator (six MIPS conditional kinds).
// Purely combinational; kinds 6 and 7 never take.
module branch_cond
  import mips_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] rs_val,
  input  logic [XLEN-1:0] rt_val,
  input  logic [2:0]      br_kind,
  output logic            br_taken
);

  logic rs_zero;
  logic rs_neg;

  assign rs_zero = (rs_val == '0);
  assign rs_neg  = rs_val[XLEN-1];

  // Select the condition for the requested kind; signed tests use the sign bit.
  always_comb begin
    br_taken = 1'b0;
    case (br_kind)
      BR_BEQ:  br_taken = (rs_val == rt_val);
      BR_BNE:  br_taken = (rs_val != rt_val);
      BR_BLEZ: br_taken = rs_neg || rs_zero;
      BR_BGTZ: br_taken = !rs_neg && !rs_zero;
      BR_BLTZ: br_taken = rs_neg;
      BR_BGEZ: br_taken = !rs_neg;
      default: br_taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage program counter for the 5-stage MIPS pipeline.
// Resolves exception/eret/jr/j/branch redirects into the next fetch PC and
// latches a D-stage redirect that arrives while instruction memory stalls.
// Optional macro PC_ALIGN_CHECK_EN builds the registered fetch_exc flag.
module pc_sequencer
  import mips_pkg::*;
#(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = XLEN'(RESET_PC_DEFAULT),
  parameter logic [XLEN-1:0] EXC_PC    = XLEN'(EXC_PC_DEFAULT),
  parameter logic [XLEN-1:0] IMEM_BASE = XLEN'(32'h0000_3000),
  parameter logic [XLEN-1:0] IMEM_TOP  = XLEN'(32'h0000_6FFC)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            imem_ready,
  input  logic            br_valid,
  input  logic [2:0]      br_kind,
  input  logic [XLEN-1:0] rs_val,
  input  logic [XLEN-1:0] rt_val,
  input  logic [XLEN-1:0] pc_d,
  input  logic [15:0]     imm16,
  input  logic            j_valid,
  input  logic [25:0]     j_index,
  input  logic            jr_valid,
  input  logic [XLEN-1:0] jr_target,
  input  logic            exc_req,
  input  logic            eret_req,
  input  logic [XLEN-1:0] epc,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc4,
  output logic            br_taken,
  output logic            redirect_pending,
  output logic            fetch_exc
);

  pcs_state_e      state_q, state_d;
  logic [XLEN-1:0] fpc_q, fpc_d;
  logic [XLEN-1:0] pend_q, pend_d;
  logic            tag_q, tag_d;          // pending entry came from M (exc/eret)
  logic            pend_exc_q, pend_exc_d;  // pending entry is an exception entry

  logic            adv;
  logic            d_redir;
  logic [XLEN-1:0] d_tgt;
  logic [XLEN-1:0] br_tgt;
  logic [XLEN-1:0] j_tgt;
  logic [XLEN-1:0] m_tgt;
  logic            pc_ld;
  logic            pc_ld_exc;

  branch_cond #(.XLEN(XLEN)) u_branch_cond (
    .rs_val   (rs_val),
    .rt_val   (rt_val),
    .br_kind  (br_kind),
    .br_taken (br_taken)
  );

  assign adv    = !stall && imem_ready;
  assign pc4    = fpc_q + XLEN'(4);
  assign br_tgt = pc_d + XLEN'(4) + {{(XLEN-18){imm16[15]}}, imm16, 2'b00};
  assign j_tgt  = {pc_d[XLEN-1:28], j_index, 2'b00};
  assign m_tgt  = exc_req ? EXC_PC : epc;

  assign pc               = fpc_q;
  assign redirect_pending = (state_q == ST_HOLD);

  // Pick the D-stage redirect target, jr before j before branch.
  always_comb begin
    d_redir = jr_valid || j_valid || (br_valid && br_taken);
    d_tgt   = br_tgt;
    if (jr_valid)     d_tgt = jr_target;
    else if (j_valid) d_tgt = j_tgt;
  end

  // Next PC and pending-redirect bookkeeping.
  // A tagged (M-stage) pending entry outranks fresh exc/eret requests, and
  // eret with imem_ready=0 is latched the same way as an exception so it is
  // never dropped.
  always_comb begin
    state_d    = state_q;
    fpc_d      = fpc_q;
    pend_d     = pend_q;
    tag_d      = tag_q;
    pend_exc_d = pend_exc_q;
    pc_ld      = 1'b0;
    pc_ld_exc  = 1'b0;
    if (state_q == ST_HOLD && tag_q) begin
      if (imem_ready) begin
        fpc_d     = pend_q;
        pc_ld     = 1'b1;
        pc_ld_exc = pend_exc_q;
        state_d   = ST_IDLE;
        tag_d     = 1'b0;
      end
    end else if (exc_req || eret_req) begin
      if (imem_ready) begin
        fpc_d     = m_tgt;
        pc_ld     = 1'b1;
        pc_ld_exc = exc_req;
        state_d   = ST_IDLE;
        tag_d     = 1'b0;
      end else begin
        pend_d     = m_tgt;
        tag_d      = 1'b1;
        pend_exc_d = exc_req;
        state_d    = ST_HOLD;
      end
    end else if (state_q == ST_HOLD) begin
      if (adv) begin
        fpc_d   = pend_q;
        pc_ld   = 1'b1;
        state_d = ST_IDLE;
      end
    end else if (adv) begin
      fpc_d = d_redir ? d_tgt : pc4;
      pc_ld = 1'b1;
    end else if (!stall && d_redir) begin
      pend_d     = d_tgt;
      tag_d      = 1'b0;
      pend_exc_d = 1'b0;
      state_d    = ST_HOLD;
    end
  end

  // State, PC and pending registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      fpc_q      <= RESET_PC;
      pend_q     <= '0;
      tag_q      <= 1'b0;
      pend_exc_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      fpc_q      <= fpc_d;
      pend_q     <= pend_d;
      tag_q      <= tag_d;
      pend_exc_q <= pend_exc_d;
    end
  end

`ifdef PC_ALIGN_CHECK_EN
  logic fexc_q, fexc_d;

  function automatic logic bad_fetch(input logic [XLEN-1:0] a);
    return (a[1:0] != 2'b00) || (a < IMEM_BASE) || (a > IMEM_TOP);
  endfunction

  // Re-evaluate the fetch check whenever the PC loads; exception entry clears it.
  always_comb begin
    fexc_d = fexc_q;
    if (pc_ld) fexc_d = pc_ld_exc ? 1'b0 : bad_fetch(fpc_d);
  end

  // Fetch-exception flag register.
  always_ff @(posedge clk) begin
    if (reset) fexc_q <= 1'b0;
    else       fexc_q <= fexc_d;
  end

  assign fetch_exc = fexc_q;
`else
  logic unused_chk;
  assign unused_chk = ^{pc_ld, pc_ld_exc, IMEM_BASE, IMEM_TOP};
  assign fetch_exc  = 1'b0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: the driver pushes hand-computed
// expectations per cycle, the monitor pops and compares on the falling edge.
module tb_pc_sequencer;
  import mips_pkg::*;

`ifdef PC_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b1;
  logic        imem_ready = 1'b0;
  logic        br_valid = 1'b0;
  logic [2:0]  br_kind = 3'd0;
  logic [31:0] rs_val = '0;
  logic [31:0] rt_val = '0;
  logic [31:0] pc_d = '0;
  logic [15:0] imm16 = '0;
  logic        j_valid = 1'b0;
  logic [25:0] j_index = '0;
  logic        jr_valid = 1'b0;
  logic [31:0] jr_target = '0;
  logic        exc_req = 1'b0;
  logic        eret_req = 1'b0;
  logic [31:0] epc = '0;
  logic [31:0] pc;
  logic [31:0] pc4;
  logic        br_taken;
  logic        redirect_pending;
  logic        fetch_exc;

  pc_sequencer #(
    .XLEN      (32),
    .RESET_PC  (32'h0000_3000),
    .EXC_PC    (32'h0000_4180),
    .IMEM_BASE (32'h0000_3000),
    .IMEM_TOP  (32'h0000_6FFC)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .stall            (stall),
    .imem_ready       (imem_ready),
    .br_valid         (br_valid),
    .br_kind          (br_kind),
    .rs_val           (rs_val),
    .rt_val           (rt_val),
    .pc_d             (pc_d),
    .imm16            (imm16),
    .j_valid          (j_valid),
    .j_index          (j_index),
    .jr_valid         (jr_valid),
    .jr_target        (jr_target),
    .exc_req          (exc_req),
    .eret_req         (eret_req),
    .epc              (epc),
    .pc               (pc),
    .pc4              (pc4),
    .br_taken         (br_taken),
    .redirect_pending (redirect_pending),
    .fetch_exc        (fetch_exc)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic        rp;
    logic        chk_bt;
    logic        bt;
    logic        fe;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;

  function automatic logic bad_fetch(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a < 32'h0000_3000) || (a > 32'h0000_6FFC);
  endfunction

  function automatic void cmp(input string nm, input string fld,
                              input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s.%s: got 0x%08h expected 0x%08h", nm, fld, act, exp);
    end
  endfunction

  // Monitor: each falling edge presents the result of the rising edge just
  // past, with that cycle's inputs still applied.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t r;
      r = sb.pop_front();
      cmp(r.name, "pc", pc, r.pc);
      cmp(r.name, "pc4", pc4, r.pc + 32'd4);
      cmp(r.name, "redirect_pending", {31'd0, redirect_pending}, {31'd0, r.rp});
      cmp(r.name, "fetch_exc", {31'd0, fetch_exc}, {31'd0, r.fe});
      if (r.chk_bt) cmp(r.name, "br_taken", {31'd0, br_taken}, {31'd0, r.bt});
    end
  end

  task automatic nxt();
    @(negedge clk);
    #1;
    reset = 1'b0; stall = 1'b0; imem_ready = 1'b1;
    br_valid = 1'b0; br_kind = 3'd0; rs_val = '0; rt_val = '0;
    pc_d = '0; imm16 = '0; j_valid = 1'b0; j_index = '0;
    jr_valid = 1'b0; jr_target = '0; exc_req = 1'b0; eret_req = 1'b0; epc = '0;
  endtask

  task automatic go(input string nm, input logic [31:0] epc_exp, input logic rp,
                    input logic cb, input logic bt);
    exp_t r;
    r.name = nm; r.pc = epc_exp; r.rp = rp; r.chk_bt = cb; r.bt = bt;
    r.fe = ALIGN && bad_fetch(epc_exp);
    sb.push_back(r);
  endtask

  task automatic br(input logic [2:0] k, input logic [31:0] rs, input logic [31:0] rt,
                    input logic [31:0] pcd, input logic [15:0] imm);
    br_valid = 1'b1; br_kind = k; rs_val = rs; rt_val = rt; pc_d = pcd; imm16 = imm;
  endtask

  initial begin
    nxt(); reset = 1'b1; stall = 1'b1; imem_ready = 1'b0;
    go("reset_a", 32'h3000, 0, 0, 0);
    nxt(); reset = 1'b1; stall = 1'b1; exc_req = 1'b1; jr_valid = 1'b1; jr_target = 32'h1234;
    go("reset_b", 32'h3000, 0, 0, 0);
    nxt(); go("seq1", 32'h3004, 0, 0, 0);
    nxt(); go("seq2", 32'h3008, 0, 0, 0);
    nxt(); br(BR_BEQ, 5, 5, 32'h3010, 16'hFFFC); go("beq_taken", 32'h3004, 0, 1, 1);
    nxt(); br(BR_BEQ, 5, 6, 32'h3010, 16'hFFFC); go("beq_not", 32'h3008, 0, 1, 0);
    nxt(); br(BR_BLTZ, 32'h8000_0000, 0, 32'h3010, 16'h0004); go("bltz_neg", 32'h3024, 0, 1, 1);
    nxt(); br(BR_BGEZ, 32'h8000_0000, 0, 32'h3010, 16'h0004); go("bgez_neg", 32'h3028, 0, 1, 0);
    nxt(); br(BR_BGEZ, 0, 0, 32'h3020, 16'h0002); go("bgez_zero", 32'h302C, 0, 1, 1);
    nxt(); br(BR_BLTZ, 0, 0, 32'h3020, 16'h0002); go("bltz_zero", 32'h3030, 0, 1, 0);
    nxt(); br(BR_BLEZ, 0, 0, 32'h3000, 16'h0001); go("blez_zero", 32'h3008, 0, 1, 1);
    nxt(); br(BR_BGTZ, 0, 0, 32'h3000, 16'h0001); go("bgtz_zero", 32'h300C, 0, 1, 0);
    nxt(); br(BR_BNE, 1, 2, 32'h3100, 16'h0000); go("bne_taken", 32'h3104, 0, 1, 1);
    nxt(); br(3'd6, 7, 7, 32'h3100, 16'h0000); go("kind6", 32'h3108, 0, 1, 0);
    nxt(); stall = 1'b1; j_valid = 1'b1; j_index = 26'h40;
    go("stall_hold", 32'h3108, 0, 0, 0);
    nxt(); imem_ready = 1'b0; j_valid = 1'b1; j_index = 26'h0000C40; pc_d = 32'h3104;
    go("pend_latch", 32'h3108, 1, 0, 0);
    nxt(); jr_valid = 1'b1; jr_target = 32'h5000;
    go("pend_apply", 32'h3100, 0, 0, 0);
    nxt(); go("after_pend", 32'h3104, 0, 0, 0);
    nxt(); imem_ready = 1'b0; j_valid = 1'b1; j_index = 26'h0000C80;
    go("pend2_latch", 32'h3104, 1, 0, 0);
    nxt(); stall = 1'b1; go("pend2_stall", 32'h3104, 1, 0, 0);
    nxt(); go("pend2_apply", 32'h3200, 0, 0, 0);
    nxt(); exc_req = 1'b1; stall = 1'b1; jr_valid = 1'b1; jr_target = 32'h3200;
    go("exc_prec", 32'h4180, 0, 0, 0);
    nxt(); eret_req = 1'b1; epc = 32'h3050; go("eret", 32'h3050, 0, 0, 0);
    nxt(); exc_req = 1'b1; eret_req = 1'b1; epc = 32'h3050; go("exc_vs_eret", 32'h4180, 0, 0, 0);
    nxt(); go("seq_exc", 32'h4184, 0, 0, 0);
    nxt(); exc_req = 1'b1; imem_ready = 1'b0; go("exc_pend", 32'h4184, 1, 0, 0);
    nxt(); stall = 1'b1; eret_req = 1'b1; epc = 32'h3050;
    go("exc_pend_apply", 32'h4180, 0, 0, 0);
    nxt(); jr_valid = 1'b1; jr_target = 32'h3300; j_valid = 1'b1; j_index = 26'h40;
    go("jr_over_j", 32'h3300, 0, 0, 0);
    nxt(); br(BR_BEQ, 9, 9, 32'hFFFF_FFF8, 16'h0002); go("br_wrap", 32'h0000_0004, 0, 1, 1);
    nxt(); jr_valid = 1'b1; jr_target = 32'h3002; go("misalign", 32'h3002, 0, 0, 0);
    nxt(); jr_valid = 1'b1; jr_target = 32'h7000; go("above_top", 32'h7000, 0, 0, 0);
    nxt(); exc_req = 1'b1; go("exc_clr", 32'h4180, 0, 0, 0);
    nxt(); jr_valid = 1'b1; jr_target = 32'h6FFC; go("at_top", 32'h6FFC, 0, 0, 0);
    nxt(); jr_valid = 1'b1; jr_target = 32'h2FFC; go("below_base", 32'h2FFC, 0, 0, 0);
    nxt(); exc_req = 1'b1; go("exc_clr2", 32'h4180, 0, 0, 0);
    nxt();
    @(negedge clk);
    #1;
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Fetch-stage program counter unit for the 5-stage MIPS pipeline.
- Holds the F-stage PC register and evaluates D-stage branch conditions (six kinds).
- Resolves j/jal, jr/jalr, exception entry and eret into a next-PC.
- Remembers a redirect that arrives while instruction memory is not accepting a fetch.
- Replaces the purely combinational next-PC selector with a parametrised, stateful block.

Parameters:
- XLEN, 32, datapath and PC width (>=32).
- RESET_PC, 32'h0000_3000, PC value after reset.
- EXC_PC, 32'h0000_4180, exception entry vector.
- IMEM_BASE, 32'h0000_3000, lowest legal fetch address (used only by the optional feature).
- IMEM_TOP, 32'h0000_6FFC, highest legal fetch address (used only by the optional feature).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hazard-unit stall; holds the PC.
- imem_ready  in  1  instruction memory accepts the fetch at pc this cycle.
- br_valid  in  1  conditional branch in D.
- br_kind  in  3  0=BEQ 1=BNE 2=BLEZ 3=BGTZ 4=BLTZ 5=BGEZ; 6 and 7 are never taken.
- rs_val  in  XLEN  forwarded rs operand in D.
- rt_val  in  XLEN  forwarded rt operand in D.
- pc_d  in  XLEN  PC of the D-stage instruction.
- imm16  in  16  branch offset.
- j_valid  in  1  j/jal in D.
- j_index  in  26  jump index.
- jr_valid  in  1  jr/jalr in D.
- jr_target  in  XLEN  forwarded rs value.
- exc_req  in  1  exception commit from M.
- eret_req  in  1  eret commit from M.
- epc  in  XLEN  return address for eret.
- pc  out  XLEN  current fetch PC.
- pc4  out  XLEN  pc+4.
- br_taken  out  1  combinational branch-condition result.
- redirect_pending  out  1  a redirect is latched and not yet applied.
- fetch_exc  out  1  misaligned or out-of-range fetch (optional feature).

Behaviour:
- Reset: pc=RESET_PC, pending cleared, redirect_pending=0, fetch_exc=0. Reset overrides all other inputs.
- Condition evaluation (signed compare for kinds 2-5):
  - BEQ: rs==rt. BNE: rs!=rt.
  - BLEZ: rs<=0. BGTZ: rs>0.
  - BLTZ: rs<0. BGEZ: rs>=0.
- Targets:
  - branch: pc_d+4+(sext(imm16)<<2), wrapping modulo 2^XLEN.
  - jump: {pc_d[XLEN-1:28], j_index, 2'b00}.
  - jr: jr_target unchanged.
- Redirect priority, highest first: exc_req -> EXC_PC; eret_req -> epc; pending; jr_valid; j_valid; br_valid&&br_taken. Otherwise pc+4.
- Advance: the PC updates only when adv = !stall && imem_ready. Exception and eret are the exception: they update the PC whenever imem_ready=1 regardless of stall, and clear pending.
- Two states:
  - IDLE: pending empty.
  - HOLD: pending valid; redirect_pending=1.
- IDLE->HOLD: a D-stage redirect (jr/j/taken branch) with !stall && !imem_ready. D has left, so the target is latched.
- HOLD->IDLE: on the next adv, pc<=pending target. A new D redirect in the same cycle is ignored (it is a delay-slot instruction and cannot be a control transfer). Exc/eret also clear HOLD.
- With stall=1 a D redirect is not latched; the stalled D instruction re-presents it.
- Delay slot: the redirect applies to the fetch after the D instruction's successor, because the PC already points at the slot. No flush output is needed.
- Simultaneous exc_req and eret_req: exc_req wins.
- exc_req with imem_ready=0: the target goes into the pending register with an exception tag, which beats all other sources until applied.

Optional Feature:
- Macro: PC_ALIGN_CHECK_EN.
- Defined: fetch_exc is a registered flag, updated with pc.
  - Set when the next pc has pc[1:0]!=0, or lies outside [IMEM_BASE, IMEM_TOP].
  - The PC still loads the bad value; the M-stage exception logic raises AdEL.
  - Cleared on reset and on exception entry.
- Undefined: fetch_exc is tied to 0 and no comparators are built.

Decomposition:
- Shared package mips_pkg:
  - br_kind encodings BR_BEQ..BR_BGEZ.
  - RESET_PC and EXC_PC default constants.
  - state encodings ST_IDLE/ST_HOLD.
- One sub-module: branch_cond (rs_val, rt_val, br_kind -> br_taken), purely combinational and reusable by the M-stage checker.

Test Plan:
- Reset: assert reset 2 cycles with stall=1 -> pc=0x3000, redirect_pending=0. Release with imem_ready=1 -> 0x3004, then 0x3008.
- BEQ taken: pc_d=0x3010, imm16=0xFFFC, rs=rt=5, br_valid=1, adv=1 -> next pc=0x3004 (backward wrap). With rs=5, rt=6 -> pc+4.
- BGEZ/BLTZ: rs=0x8000_0000 -> BLTZ taken, BGEZ not taken. rs=0 -> BGEZ taken, BLTZ not, BLEZ taken, BGTZ not.
- Pending redirect: j_index=0x0000C40, imem_ready=0 -> redirect_pending=1, pc unchanged. Next cycle imem_ready=1 -> pc=0x0000_3100, pending=0.
- Exception precedence: exc_req=1, stall=1, jr_valid=1, jr_target=0x3200 -> pc=0x4180. Then eret_req=1, epc=0x3050 -> pc=0x3050.
- PC_ALIGN_CHECK_EN: jr_target=0x3002 -> pc=0x3002, fetch_exc=1. jr_target=0x7000 -> fetch_exc=1. Next exc_req -> fetch_exc=0.
